// File: rtl/i3c_timec_pkg.sv
// Shared definitions for the time-control IBI sequencer: state encoding,
// timestamp byte selectors and counter widths.
`timescale 1ns/1ps
package i3c_timec_pkg;

   localparam int RETRY_W = 3;
   localparam int TMO_W   = 8;

   // Bit of timec_ena that appends timestamp bytes to the IBI payload
   localparam int TIMEC_ENA_TS = 0;

   localparam logic [2:0] TSEL_NONE = 3'd0;
   localparam logic [2:0] TSEL_TC1L = 3'd5;
   localparam logic [2:0] TSEL_TC1H = 3'd6;
   localparam logic [2:0] TSEL_TC2  = 3'd7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_STAMP_WAIT,
      ST_ARB,
      ST_MDB,
      ST_TC1L,
      ST_TC1H,
      ST_TC2,
`ifdef I3C_TIMEC_CHKSUM_EN
      ST_CHK,
`endif
      ST_DONE
   } state_t;

   function automatic logic [2:0] tsel_of(input state_t st);
      case (st)
         ST_TC1L: return TSEL_TC1L;
         ST_TC1H: return TSEL_TC1H;
         ST_TC2:  return TSEL_TC2;
         default: return TSEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/i3c_timec_retry_tmo.sv
// NACK retry counter and stamp_done timeout counter for the IBI sequencer.
// retry_last flags that the next NACK exhausts the retry budget.
`timescale 1ns/1ps
module i3c_timec_retry_tmo
   import i3c_timec_pkg::*;
#(
   parameter int MAX_RETRY = 2,
   parameter int STAMP_TMO = 255
) (
   input  logic CLK_SLOW,
   input  logic RSTn,
   input  logic retry_clr,
   input  logic retry_inc,
   input  logic tmo_clr,
   input  logic tmo_inc,
   output logic retry_last,
   output logic tmo_expired
);

   logic [RETRY_W-1:0] retry_cnt;
   logic [TMO_W-1:0]   tmo_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge CLK_SLOW or negedge RSTn) begin
      if (!RSTn) begin
         retry_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         if (retry_clr)      retry_cnt <= '0;
         else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;

         if (tmo_clr)        tmo_cnt <= '0;
         else if (tmo_inc)   tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign retry_last  = (retry_cnt == RETRY_W'(MAX_RETRY - 1));
   assign tmo_expired = (tmo_cnt == TMO_W'(STAMP_TMO - 1));

endmodule

// File: rtl/i3c_timec_ibi_seq.sv
// IBI sequencer streaming MDB plus optional timestamp bytes with NACK retry,
// abort and overflow fallback. Macro I3C_TIMEC_CHKSUM_EN appends an XOR byte.
`timescale 1ns/1ps
module i3c_timec_ibi_seq
   import i3c_timec_pkg::*;
#(
   parameter int MAX_RETRY = 2,
   parameter int STAMP_TMO = 255
) (
   input  logic       CLK_SLOW,
   input  logic       RSTn,
   input  logic [2:0] timec_ena,
   input  logic       ibi_req,
   input  logic [7:0] mdb,
   input  logic       stamp_done,
   input  logic       time_overflow,
   input  logic [7:0] time_info_byte,
   output logic [2:0] time_info_sel,
   output logic       ibi_arb_req,
   input  logic       ibi_acked,
   input  logic       ibi_nacked,
   input  logic       bus_abort,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_last,
   input  logic       byte_take,
   output logic       ibi_done,
   output logic       ibi_fail,
   output logic       tc_ovf_flag
);

   state_t     state;
   logic [7:0] mdb_q;
   logic       short_q;
   logic       arb_gap;
   logic       retry_last;
   logic       tmo_expired;
   logic       data_state;
   logic       unused_ena;

`ifdef I3C_TIMEC_CHKSUM_EN
   logic [7:0] chk_q;
   localparam state_t ST_LAST = ST_CHK;
`else
   localparam state_t ST_LAST = ST_TC2;
`endif

   assign unused_ena = &{1'b0, timec_ena[2:1]};

   i3c_timec_retry_tmo #(
      .MAX_RETRY (MAX_RETRY),
      .STAMP_TMO (STAMP_TMO)
   ) u_retry_tmo (
      .CLK_SLOW    (CLK_SLOW),
      .RSTn        (RSTn),
      .retry_clr   (state == ST_IDLE),
      .retry_inc   (state == ST_ARB && !arb_gap && ibi_nacked),
      .tmo_clr     (state != ST_STAMP_WAIT),
      .tmo_inc     (state == ST_STAMP_WAIT),
      .retry_last  (retry_last),
      .tmo_expired (tmo_expired)
   );

   assign data_state    = (state == ST_MDB) || (state == ST_TC1L) || (state == ST_TC1H) ||
                          (state == ST_TC2) || (state == ST_LAST);
   assign byte_valid    = data_state;
   assign byte_last     = (state == ST_MDB && short_q) || (state == ST_LAST);
   assign time_info_sel = tsel_of(state);
   assign ibi_arb_req   = (state == ST_ARB) && !arb_gap;
   assign ibi_done      = (state == ST_DONE);

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      byte_data = 8'h00;
      case (state)
         ST_MDB:                    byte_data = mdb_q;
         ST_TC1L, ST_TC1H, ST_TC2:  byte_data = time_info_byte;
`ifdef I3C_TIMEC_CHKSUM_EN
         ST_CHK:                    byte_data = chk_q;
`endif
         default:                   byte_data = 8'h00;
      endcase
   end

   always_ff @(posedge CLK_SLOW or negedge RSTn) begin
      if (!RSTn) begin
         state       <= ST_IDLE;
         mdb_q       <= 8'h00;
         short_q     <= 1'b0;
         arb_gap     <= 1'b0;
         ibi_fail    <= 1'b0;
         tc_ovf_flag <= 1'b0;
`ifdef I3C_TIMEC_CHKSUM_EN
         chk_q       <= 8'h00;
`endif
      end else begin
         ibi_fail <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ibi_req) begin
                  mdb_q   <= mdb;
                  arb_gap <= 1'b0;
`ifdef I3C_TIMEC_CHKSUM_EN
                  chk_q   <= 8'h00;
`endif
                  if (timec_ena[TIMEC_ENA_TS]) begin
                     tc_ovf_flag <= 1'b0;
                     short_q     <= 1'b0;
                     state       <= ST_STAMP_WAIT;
                  end else begin
                     short_q <= 1'b1;
                     state   <= ST_ARB;
                  end
               end
            end
            ST_STAMP_WAIT: begin
               if (!ibi_req) begin
                  state <= ST_IDLE;
               end else if (stamp_done) begin
                  short_q     <= time_overflow;
                  tc_ovf_flag <= tc_ovf_flag | time_overflow;
                  state       <= ST_ARB;
               end else if (tmo_expired) begin
                  short_q     <= 1'b1;
                  tc_ovf_flag <= 1'b1;
                  state       <= ST_ARB;
               end
            end
            ST_ARB: begin
               // One idle cycle with the request dropped between NACKed attempts
               if (arb_gap) begin
                  arb_gap <= 1'b0;
                  if (!ibi_req) state <= ST_IDLE;
               end else if (ibi_nacked) begin
                  if (retry_last) begin
                     ibi_fail <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     arb_gap <= 1'b1;
                  end
               end else if (ibi_acked) begin
                  state <= ST_MDB;
               end else if (!ibi_req) begin
                  state <= ST_IDLE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: begin
               if (bus_abort) begin
                  ibi_fail <= 1'b1;
                  state    <= ST_IDLE;
               end else if (byte_take) begin
`ifdef I3C_TIMEC_CHKSUM_EN
                  chk_q <= chk_q ^ byte_data;
`endif
                  case (state)
                     ST_MDB:  state <= short_q ? ST_DONE : ST_TC1L;
                     ST_TC1L: state <= ST_TC1H;
                     ST_TC1H: state <= ST_TC2;
`ifdef I3C_TIMEC_CHKSUM_EN
                     ST_TC2:  state <= ST_CHK;
`endif
                     default: state <= ST_DONE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i3c_timec_ibi_seq.sv
// Directed bench for i3c_timec_ibi_seq with a payload scoreboard; follows
// I3C_TIMEC_CHKSUM_EN to expect the trailing XOR byte.
`timescale 1ns/1ps
module tb_i3c_timec_ibi_seq;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] sel;
      logic       last;
   } exp_t;

   logic       CLK_SLOW = 1'b0;
   logic       RSTn = 1'b0;
   logic [2:0] timec_ena = '0;
   logic       ibi_req = 1'b0;
   logic [7:0] mdb = '0;
   logic       stamp_done = 1'b0;
   logic       time_overflow = 1'b0;
   logic [7:0] time_info_byte;
   logic [2:0] time_info_sel;
   logic       ibi_arb_req;
   logic       ibi_acked = 1'b0;
   logic       ibi_nacked = 1'b0;
   logic       bus_abort = 1'b0;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_last;
   logic       byte_take = 1'b0;
   logic       ibi_done;
   logic       ibi_fail;
   logic       tc_ovf_flag;

   logic [15:0] tc1 = 16'h0000;
   logic [7:0]  tc2 = 8'h00;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   always #5 CLK_SLOW = ~CLK_SLOW;

   // Timestamp block model: byte selected by time_info_sel
   always_comb begin
      case (time_info_sel)
         3'd5:    time_info_byte = tc1[7:0];
         3'd6:    time_info_byte = tc1[15:8];
         3'd7:    time_info_byte = tc2;
         default: time_info_byte = 8'h00;
      endcase
   end

   i3c_timec_ibi_seq dut (
      .CLK_SLOW       (CLK_SLOW),
      .RSTn           (RSTn),
      .timec_ena      (timec_ena),
      .ibi_req        (ibi_req),
      .mdb            (mdb),
      .stamp_done     (stamp_done),
      .time_overflow  (time_overflow),
      .time_info_byte (time_info_byte),
      .time_info_sel  (time_info_sel),
      .ibi_arb_req    (ibi_arb_req),
      .ibi_acked      (ibi_acked),
      .ibi_nacked     (ibi_nacked),
      .bus_abort      (bus_abort),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_last      (byte_last),
      .byte_take      (byte_take),
      .ibi_done       (ibi_done),
      .ibi_fail       (ibi_fail),
      .tc_ovf_flag    (tc_ovf_flag)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK_SLOW);
   endtask

   task automatic request(input logic [2:0] ena, input logic [7:0] m);
      timec_ena = ena;
      mdb       = m;
      ibi_req   = 1'b1;
      tick();
   endtask

   task automatic ack();
      ibi_acked = 1'b1;
      tick();
      ibi_acked = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] s, input logic l);
      exp_t e;
      e.data = d;
      e.sel  = s;
      e.last = l;
      sb.push_back(e);
   endtask

   task automatic push_full(input logic [7:0] m);
`ifdef I3C_TIMEC_CHKSUM_EN
      push(m, 3'd0, 1'b0);
      push(tc1[7:0], 3'd5, 1'b0);
      push(tc1[15:8], 3'd6, 1'b0);
      push(tc2, 3'd7, 1'b0);
      push(m ^ tc1[7:0] ^ tc1[15:8] ^ tc2, 3'd0, 1'b1);
`else
      push(m, 3'd0, 1'b0);
      push(tc1[7:0], 3'd5, 1'b0);
      push(tc1[15:8], 3'd6, 1'b0);
      push(tc2, 3'd7, 1'b1);
`endif
   endtask

   // Compare and take the next n bytes against the scoreboard
   task automatic take_bytes(input int n);
      exp_t e;
      int   w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!byte_valid && w < 20) begin
            tick();
            w++;
         end
         check("byte_valid", 16'(byte_valid), 16'd1);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed byte %0h expected none", byte_data);
         end else begin
            e = sb.pop_front();
            check("byte_data", 16'(byte_data), 16'(e.data));
            check("time_info_sel", 16'(time_info_sel), 16'(e.sel));
            check("byte_last", 16'(byte_last), 16'(e.last));
         end
         check("done_early", 16'(ibi_done), 16'd0);
         byte_take = 1'b1;
         tick();
         byte_take = 1'b0;
      end
   endtask

   task automatic finish_done();
      check("ibi_done_pulse", 16'(ibi_done), 16'd1);
      check("byte_valid_done", 16'(byte_valid), 16'd0);
      tick();
      check("ibi_done_once", 16'(ibi_done), 16'd0);
      check("sb_drained", 16'(sb.size()), 16'd0);
   endtask

`ifdef I3C_TIMEC_CHKSUM_EN
   localparam int FULL_N = 5;
`else
   localparam int FULL_N = 4;
`endif

   initial begin
      int n;

      // Reset state
      tick();
      check("rst_arb_req", 16'(ibi_arb_req), 16'd0);
      check("rst_byte_valid", 16'(byte_valid), 16'd0);
      check("rst_byte_data", 16'(byte_data), 16'd0);
      check("rst_byte_last", 16'(byte_last), 16'd0);
      check("rst_sel", 16'(time_info_sel), 16'd0);
      check("rst_done", 16'(ibi_done), 16'd0);
      check("rst_fail", 16'(ibi_fail), 16'd0);
      check("rst_ovf", 16'(tc_ovf_flag), 16'd0);
      RSTn = 1'b1;
      tick();

      // Full payload with timestamps
      tc1 = 16'h1234;
      tc2 = 8'h56;
      request(3'd1, 8'hA5);
      check("full_stamp_wait_arb", 16'(ibi_arb_req), 16'd0);
      stamp_done = 1'b1;
      tick();
      stamp_done = 1'b0;
      check("full_arb_req", 16'(ibi_arb_req), 16'd1);
      push_full(8'hA5);
      ack();
      ibi_req = 1'b0;
      check("full_arb_drop", 16'(ibi_arb_req), 16'd0);
      take_bytes(FULL_N);
      finish_done();
      check("full_ovf", 16'(tc_ovf_flag), 16'd0);

      // Time control off; a take while no byte is valid must be ignored
      request(3'd0, 8'h3C);
      check("off_arb_req", 16'(ibi_arb_req), 16'd1);
      byte_take = 1'b1;
      tick();
      byte_take = 1'b0;
      push(8'h3C, 3'd0, 1'b1);
      ack();
      ibi_req = 1'b0;
      take_bytes(1);
      finish_done();
      check("off_ovf", 16'(tc_ovf_flag), 16'd0);

      // Stamp timeout fallback
      request(3'd1, 8'h77);
      n = 0;
      while (!ibi_arb_req && n < 400) begin
         tick();
         n++;
      end
      check("tmo_cycles", 16'(n), 16'd255);
      check("tmo_ovf", 16'(tc_ovf_flag), 16'd1);
      push(8'h77, 3'd0, 1'b1);
      ack();
      ibi_req = 1'b0;
      take_bytes(1);
      finish_done();
      check("tmo_ovf_sticky", 16'(tc_ovf_flag), 16'd1);

      // Stamp with overflow: flag cleared on accept, then set again
      request(3'd1, 8'h5A);
      check("ovf_flag_cleared", 16'(tc_ovf_flag), 16'd0);
      stamp_done    = 1'b1;
      time_overflow = 1'b1;
      tick();
      stamp_done    = 1'b0;
      time_overflow = 1'b0;
      check("ovf_flag_set", 16'(tc_ovf_flag), 16'd1);
      check("ovf_arb_req", 16'(ibi_arb_req), 16'd1);
      push(8'h5A, 3'd0, 1'b1);
      ack();
      ibi_req = 1'b0;
      take_bytes(1);
      finish_done();

      // NACK retry exhaustion
      request(3'd0, 8'h11);
      check("nack_arb1", 16'(ibi_arb_req), 16'd1);
      ibi_nacked = 1'b1;
      tick();
      ibi_nacked = 1'b0;
      check("nack_gap", 16'(ibi_arb_req), 16'd0);
      check("nack_gap_fail", 16'(ibi_fail), 16'd0);
      tick();
      check("nack_arb2", 16'(ibi_arb_req), 16'd1);
      ibi_nacked = 1'b1;
      tick();
      ibi_nacked = 1'b0;
      ibi_req    = 1'b0;
      check("nack_fail", 16'(ibi_fail), 16'd1);
      check("nack_arb_off", 16'(ibi_arb_req), 16'd0);
      tick();
      check("nack_fail_pulse", 16'(ibi_fail), 16'd0);
      check("nack_idle_arb", 16'(ibi_arb_req), 16'd0);

      // Abort coinciding with a take in TC1H
      tc1 = 16'hBEEF;
      tc2 = 8'h42;
      request(3'd1, 8'hC3);
      stamp_done = 1'b1;
      tick();
      stamp_done = 1'b0;
      push_full(8'hC3);
      ack();
      ibi_req = 1'b0;
      take_bytes(2);
      check("abort_tc1h_sel", 16'(time_info_sel), 16'd6);
      check("abort_tc1h_data", 16'(byte_data), 16'hBE);
      byte_take = 1'b1;
      bus_abort = 1'b1;
      tick();
      byte_take = 1'b0;
      bus_abort = 1'b0;
      check("abort_fail", 16'(ibi_fail), 16'd1);
      check("abort_valid", 16'(byte_valid), 16'd0);
      check("abort_no_done", 16'(ibi_done), 16'd0);
      tick();
      check("abort_fail_pulse", 16'(ibi_fail), 16'd0);
      check("abort_no_done2", 16'(ibi_done), 16'd0);
      sb.delete();

      // Cancel in STAMP_WAIT, then a late stamp must not start arbitration
      request(3'd1, 8'h99);
      tick();
      ibi_req = 1'b0;
      tick();
      stamp_done = 1'b1;
      tick();
      stamp_done = 1'b0;
      check("cancel_arb", 16'(ibi_arb_req), 16'd0);
      check("cancel_fail", 16'(ibi_fail), 16'd0);
      check("cancel_done", 16'(ibi_done), 16'd0);

      // Reset in the middle of a payload
      request(3'd0, 8'h66);
      ack();
      check("midrst_valid_before", 16'(byte_valid), 16'd1);
      ibi_req = 1'b0;
      RSTn    = 1'b0;
      #1;
      check("midrst_valid", 16'(byte_valid), 16'd0);
      check("midrst_data", 16'(byte_data), 16'd0);
      check("midrst_arb", 16'(ibi_arb_req), 16'd0);
      tick();
      RSTn = 1'b1;
      tick();
      check("midrst_idle", 16'(byte_valid), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
